// File: rtl/alu_z.sv
// alu_z: 16-bit ALU with Z result register, flags, tri-state DATA bus and iterative shift-add multiplier
module alu_z (
  input  logic        clk,
  input  logic        reset,
  inout  wire  [15:0] DATA,
  input  logic [15:0] Y_IN,
  input  logic [3:0]  ALU_OP,
  input  logic        Z_in,
  input  logic        Z_out,
  output logic [15:0] REG_OUT_Z,
  output logic [3:0]  FLAGS,
  output logic        BUSY,
  output logic        DONE
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t             state_q;
  logic        [15:0] z_q, mplier_q;
  logic        [31:0] mcand_q, acc_q, acc_d;
  logic        [3:0]  cnt_q, flags_q;
  logic               done_q;
  logic        [15:0] a, b, bb, r;
  logic               c, v, ok;
  logic        [16:0] sum, diff, shl, shr;
  logic signed [16:0] asr;

  assign DATA      = Z_out ? z_q : 16'hzzzz;
  assign REG_OUT_Z = z_q;
  assign FLAGS     = flags_q;
  assign BUSY      = state_q == RUN;
  assign DONE      = done_q;

  assign a     = Y_IN;
  assign b     = DATA;
  assign bb    = ALU_OP == 4'd10 ? 16'd1 : b;
  assign sum   = {1'b0, a} + {1'b0, bb};
  assign diff  = {1'b0, a} - {1'b0, b};
  // shifts carry one guard bit so the last bit shifted out lands in it (0 when amount is 0)
  assign shl   = {1'b0, a} << b[3:0];
  assign shr   = {a, 1'b0} >> b[3:0];
  assign asr   = $signed({a, 1'b0}) >>> b[3:0];
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : 32'h0);

  // single-cycle result and flag generation; ok is low for MUL and reserved ops
  always_comb begin
    r  = 16'h0;
    c  = 1'b0;
    v  = 1'b0;
    ok = 1'b1;
    case (ALU_OP)
      4'd0, 4'd10: begin
        r = sum[15:0];
        c = sum[16];
        v = (a[15] == bb[15]) && (r[15] != a[15]);
      end
      4'd1: begin
        r = diff[15:0];
        c = diff[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = ~b;
      4'd6:    {c, r} = shl;
      4'd7:    {r, c} = shr;
      4'd8:    {r, c} = asr;
      4'd9:    r = b;
      default: ok = 1'b0;
    endcase
  end

  // IDLE commits single-cycle ops or launches MUL; RUN does one shift-add step per cycle for 16 cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      z_q      <= 16'h0;
      flags_q  <= 4'h0;
      done_q   <= 1'b0;
      cnt_q    <= 4'h0;
      mcand_q  <= 32'h0;
      mplier_q <= 16'h0;
      acc_q    <= 32'h0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (Z_in && ok) begin
          z_q     <= r;
          flags_q <= {r[15], r == 16'h0, c, v};
        end else if (Z_in && ALU_OP == 4'd11) begin
          state_q  <= RUN;
          cnt_q    <= 4'h0;
          mcand_q  <= {16'h0, a};
          mplier_q <= b;
          acc_q    <= 32'h0;
        end
      end else begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          z_q     <= acc_d[15:0];
          flags_q <= {acc_d[15], acc_d[15:0] == 16'h0, |acc_d[31:16], |acc_d[31:16]};
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_z.sv
// tb_alu_z: vector table plus scoreboard for single-cycle ops, hand sequences for multiply, bus and reset
module tb_alu_z;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] Y_IN = 16'h0;
  logic [3:0]  ALU_OP = 4'h0;
  logic        Z_in = 1'b0;
  logic        Z_out = 1'b0;
  logic [15:0] REG_OUT_Z;
  logic [3:0]  FLAGS;
  logic        BUSY, DONE;
  logic        drv_en = 1'b0;
  logic [15:0] drv_v = 16'h0;
  wire  [15:0] data;

  assign data = drv_en ? drv_v : 16'hzzzz;

  alu_z dut (
    .clk(clk), .reset(reset), .DATA(data), .Y_IN(Y_IN), .ALU_OP(ALU_OP), .Z_in(Z_in),
    .Z_out(Z_out), .REG_OUT_Z(REG_OUT_Z), .FLAGS(FLAGS), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [3:0] op; logic [15:0] a, b, z; logic [3:0] f;} vec_t;
  typedef struct packed {logic [15:0] z; logic [3:0] f;} exp_t;
  localparam int NV = 20;
  vec_t vt[NV];
  exp_t sb[$];
  exp_t e;
  int   n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic mul_seq(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ez, input logic [3:0] ef,
                         input int pulse_at, input logic [15:0] pre_z);
    int nb, zbad;
    @(negedge clk);
    Y_IN = a; drv_en = 1'b1; drv_v = b; ALU_OP = 4'd11; Z_in = 1'b1;
    @(negedge clk);
    Z_in = 1'b0; drv_v = 16'hFFFF; Y_IN = 16'h5555;
    nb = 0;
    zbad = 0;
    for (int k = 0; k < 40 && BUSY; k++) begin
      nb++;
      if (REG_OUT_Z !== pre_z || DONE !== 1'b0) zbad++;
      if (nb >= 3 && data !== pre_z) zbad++;
      if (nb == 2) begin drv_en = 1'b0; Z_out = 1'b1; end
      if (nb == pulse_at) begin Z_in = 1'b1; ALU_OP = 4'd0; end else Z_in = 1'b0;
      @(negedge clk);
    end
    Z_in = 1'b0; Z_out = 1'b0;
    chk({nm, "_busy_cycles"}, nb, 16);
    chk({nm, "_run_hold"}, zbad, 0);
    chk({nm, "_result"}, {11'h0, REG_OUT_Z, FLAGS, DONE}, {11'h0, ez, ef, 1'b1});
    @(negedge clk);
    chk({nm, "_done_pulse"}, {30'h0, BUSY, DONE}, 32'h0);
  endtask

  initial begin
    int nd;
    vt[0]  = '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b1001};
    vt[1]  = '{4'd1,  16'h0003, 16'h0005, 16'hFFFE, 4'b1010};
    vt[2]  = '{4'd8,  16'h8001, 16'h0001, 16'hC000, 4'b1010};
    vt[3]  = '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b0110};
    vt[4]  = '{4'd2,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000};
    vt[5]  = '{4'd3,  16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000};
    vt[6]  = '{4'd4,  16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100};
    vt[7]  = '{4'd5,  16'h1234, 16'h0000, 16'hFFFF, 4'b1000};
    vt[8]  = '{4'd6,  16'h8001, 16'h0001, 16'h0002, 4'b0010};
    vt[9]  = '{4'd6,  16'h1234, 16'h0000, 16'h1234, 4'b0000};
    vt[10] = '{4'd7,  16'h0003, 16'h0001, 16'h0001, 4'b0010};
    vt[11] = '{4'd7,  16'h8000, 16'h000F, 16'h0001, 4'b0000};
    vt[12] = '{4'd8,  16'h8000, 16'h0004, 16'hF800, 4'b1000};
    vt[13] = '{4'd9,  16'h0000, 16'h8000, 16'h8000, 4'b1000};
    vt[14] = '{4'd10, 16'h7FFF, 16'h0000, 16'h8000, 4'b1001};
    vt[15] = '{4'd10, 16'hFFFF, 16'h1234, 16'h0000, 4'b0110};
    vt[16] = '{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'b0001};
    vt[17] = '{4'd1,  16'h0005, 16'h0005, 16'h0000, 4'b0100};
    vt[18] = '{4'd12, 16'h0001, 16'h0001, 16'h0000, 4'b0100};
    vt[19] = '{4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100};

    Z_out = 1'b1;
    #1;
    chk("reset_state", {10'h0, REG_OUT_Z, FLAGS, BUSY, DONE}, 32'h0);
    chk("reset_bus", {16'h0, data}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; Z_out = 1'b0; drv_en = 1'b1;

    for (int i = 0; i <= NV; i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("vec%0d", i - 1), {10'h0, REG_OUT_Z, FLAGS, BUSY, DONE}, {10'h0, e.z, e.f, 2'b00});
      end
      if (i < NV) begin
        Y_IN = vt[i].a; drv_v = vt[i].b; ALU_OP = vt[i].op; Z_in = 1'b1;
        sb.push_back('{vt[i].z, vt[i].f});
      end else Z_in = 1'b0;
    end

    Y_IN = 16'h0; drv_v = 16'h0005; ALU_OP = 4'd0; Z_in = 1'b1;
    @(negedge clk);
    chk("load5", {16'h0, REG_OUT_Z}, 32'h5);
    drv_en = 1'b0; Z_out = 1'b1; Y_IN = 16'h0001;
    @(negedge clk);
    chk("zio_first", {12'h0, REG_OUT_Z, FLAGS}, {12'h0, 16'h0006, 4'b0000});
    @(negedge clk);
    chk("zio_second", {16'h0, REG_OUT_Z}, 32'h7);
    Z_in = 1'b0;
    #1;
    chk("bus_drive", {16'h0, data}, 32'h7);
    Z_out = 1'b0; drv_en = 1'b1; drv_v = 16'hA5A5;
    #1;
    chk("bus_release", {16'h0, data}, 32'hA5A5);

    mul_seq("mul_ovf", 16'h1000, 16'h0010, 16'h0000, 4'b0111, 5, 16'h0007);
    mul_seq("mul_basic", 16'h0123, 16'h0045, 16'h4E6F, 4'b0000, 0, 16'h0000);

    @(negedge clk);
    Y_IN = 16'h0003; drv_en = 1'b1; drv_v = 16'h0004; ALU_OP = 4'd11; Z_in = 1'b1;
    @(negedge clk);
    Z_in = 1'b0;
    nd = 0;
    for (int k = 0; k < 8 && BUSY; k++) begin nd++; @(negedge clk); end
    chk("abort_reach8", nd, 8);
    #2 reset = 1'b0;
    #1;
    chk("abort_clear", {10'h0, REG_OUT_Z, FLAGS, BUSY, DONE}, 32'h0);
    @(negedge clk);
    reset = 1'b1; Y_IN = 16'h0002; drv_v = 16'h0003; ALU_OP = 4'd0; Z_in = 1'b1;
    @(negedge clk);
    Z_in = 1'b0;
    chk("post_reset_add", {12'h0, REG_OUT_Z, FLAGS}, {12'h0, 16'h0005, 4'b0000});
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      if (DONE || BUSY) nd++;
      @(negedge clk);
    end
    chk("abort_no_done", nd, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
